// File: rtl/vpu_wb_burst_unit_pkg.sv
// Shared types and defaults for the VPU write-back burst unit.
// The waddr helpers split {bank id, word addr} at the default geometry.
package vpu_wb_burst_unit_pkg;
  localparam int LANE_W_D         = 256;
  localparam int WORD_W_D         = 1024;
  localparam int BEATS_MAX_D      = 4;
  localparam int BANK_CNT_LG2_D   = 3;
  localparam int BANK_DEPTH_LG2_D = 10;
  localparam int WADDR_W_D        = BANK_CNT_LG2_D + BANK_DEPTH_LG2_D;

  typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_state_t;

  function automatic logic [BANK_CNT_LG2_D-1:0] get_bank_id(input logic [WADDR_W_D-1:0] waddr);
    return waddr[WADDR_W_D-1 -: BANK_CNT_LG2_D];
  endfunction

  function automatic logic [BANK_DEPTH_LG2_D-1:0] get_waddr(input logic [WADDR_W_D-1:0] waddr);
    return waddr[BANK_DEPTH_LG2_D-1:0];
  endfunction
endpackage

// File: rtl/vpu_wb_pingpong_buf.sv
// Two word-wide buffers: lane chunks are packed into buf[wsel] while buf[rsel]
// is drained to SRAM. Exposes next-cycle full/rsel so the top can present beats without a bubble.
module vpu_wb_pingpong_buf #(
  parameter int LANE_W = 256,
  parameter int WORD_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_fill,
  input  logic [LANE_W-1:0] i_chunk,
  input  logic              i_free,
  output logic              o_wr_free,
  output logic [WORD_W-1:0] o_rdata,
  output logic [1:0]        o_full_nxt,
  output logic              o_rsel_nxt
);
  localparam int CPW   = WORD_W / LANE_W;
  localparam int PTR_W = (CPW > 1) ? $clog2(CPW) : 1;

  logic [1:0][WORD_W-1:0] r_buf;
  logic [1:0]             r_full;
  logic                   r_wsel;
  logic                   r_rsel;
  logic [PTR_W-1:0]       r_ptr;
  logic                   w_word_done;
  logic [1:0]             w_full_nxt;

  assign w_word_done = i_fill && (r_ptr == PTR_W'(CPW - 1));

  // A fill of one buffer and a free of the other may land in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (i_free)      w_full_nxt[r_rsel] = 1'b0;
    if (w_word_done) w_full_nxt[r_wsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_buf  <= '0;
      r_full <= '0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_ptr  <= '0;
    end else begin
      if (i_fill) begin
        r_buf[r_wsel][r_ptr*LANE_W +: LANE_W] <= i_chunk;
        r_ptr <= w_word_done ? '0 : r_ptr + 1'b1;
      end
      if (w_word_done) r_wsel <= ~r_wsel;
      if (i_free)      r_rsel <= ~r_rsel;
      r_full <= w_full_nxt;
    end
  end

  assign o_wr_free  = !r_full[r_wsel];
  assign o_rdata    = r_buf[r_rsel];
  assign o_full_nxt = w_full_nxt;
  assign o_rsel_nxt = r_rsel ^ i_free;
endmodule

// File: rtl/vpu_wb_burst_unit.sv
// VPU write-back: packs lane chunks into SRAM words and bursts 1..BEATS_MAX
// consecutive words into one bank, overlapping packing with the SRAM write.
module vpu_wb_burst_unit
  import vpu_wb_burst_unit_pkg::*;
#(
  parameter int LANE_W         = LANE_W_D,
  parameter int WORD_W         = WORD_W_D,
  parameter int BEATS_MAX      = BEATS_MAX_D,
  parameter int BANK_CNT_LG2   = BANK_CNT_LG2_D,
  parameter int BANK_DEPTH_LG2 = BANK_DEPTH_LG2_D
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 reset_cmd_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [BANK_CNT_LG2+BANK_DEPTH_LG2-1:0] req_waddr_i,
  input  logic [$clog2(BEATS_MAX+1)-1:0]       req_beats_i,
  input  logic                                 wb_data_valid_i,
  output logic                                 wb_data_ready_o,
  input  logic [LANE_W-1:0]                    wb_data_i,
  output logic                                 wb_done_o,
  output logic                                 w_req_o,
  input  logic                                 w_ack_i,
  output logic [BANK_CNT_LG2-1:0]              w_wid_o,
  output logic [BANK_DEPTH_LG2-1:0]            w_addr_o,
  output logic                                 w_web_o,
  output logic                                 w_wlast_o,
  output logic [WORD_W-1:0]                    w_wdata_o
);
  localparam int CPW    = WORD_W / LANE_W;
  localparam int BEAT_W = $clog2(BEATS_MAX + 1);
  localparam int CNT_W  = $clog2(BEATS_MAX * CPW + 1);

  wb_state_t                 r_state, w_state_nxt;
  logic [BANK_CNT_LG2-1:0]   r_bank;
  logic [BANK_DEPTH_LG2-1:0] r_base;
  logic [BEAT_W-1:0]         r_beats;
  logic [BEAT_W-1:0]         r_beat_idx;
  logic [CNT_W-1:0]          r_chunks;

  logic              w_run, w_accept, w_abort, w_fill, w_ack, w_last_ack, w_load;
  logic              w_wr_free, w_rsel_nxt;
  logic [1:0]        w_full_nxt;
  logic [WORD_W-1:0] w_rdata;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [CNT_W-1:0]  w_total;

  assign w_run      = (r_state == WB_RUN);
  assign w_accept   = (r_state == WB_IDLE) && req_valid_i && !reset_cmd_i;
  assign w_abort    = w_run && reset_cmd_i;
  assign w_total    = CNT_W'(r_beats) * CNT_W'(CPW);
  assign w_fill     = wb_data_valid_i && wb_data_ready_o;
  assign w_ack      = w_req_o && w_ack_i;
  assign w_last_ack = w_ack && w_wlast_o;
  assign w_beat_nxt = r_beat_idx + BEAT_W'(w_ack);

  assign wb_data_ready_o = w_run && w_wr_free && (r_chunks < w_total);

  // Present the next beat as soon as its buffer is (or is becoming) full.
  assign w_load = w_run && !reset_cmd_i && !w_last_ack && w_full_nxt[w_rsel_nxt];

  vpu_wb_pingpong_buf #(.LANE_W(LANE_W), .WORD_W(WORD_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_abort),
    .i_fill     (w_fill),
    .i_chunk    (wb_data_i),
    .i_free     (w_ack),
    .o_wr_free  (w_wr_free),
    .o_rdata    (w_rdata),
    .o_full_nxt (w_full_nxt),
    .o_rsel_nxt (w_rsel_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    wb_done_o   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) w_state_nxt = (req_beats_i == '0) ? WB_DONE : WB_RUN;
      end
      WB_RUN: begin
        if (reset_cmd_i)     w_state_nxt = WB_IDLE;
        else if (w_last_ack) w_state_nxt = WB_DONE;
      end
      WB_DONE: begin
        wb_done_o = 1'b1;
        if (reset_cmd_i) w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank     <= '0;
      r_base     <= '0;
      r_beats    <= '0;
      r_beat_idx <= '0;
      r_chunks   <= '0;
    end else if (w_accept) begin
      r_bank     <= req_waddr_i[BANK_DEPTH_LG2 +: BANK_CNT_LG2];
      r_base     <= req_waddr_i[BANK_DEPTH_LG2-1:0];
      r_beats    <= req_beats_i;
      r_beat_idx <= '0;
      r_chunks   <= '0;
    end else if (w_run) begin
      if (w_fill) r_chunks   <= r_chunks + 1'b1;
      if (w_ack)  r_beat_idx <= w_beat_nxt;
    end
  end

  // SRAM port: held while stalled, reloaded back-to-back on ack, idled otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort) begin
      w_req_o   <= 1'b0;
      w_web_o   <= 1'b1;
      w_wlast_o <= 1'b0;
      w_wid_o   <= '0;
      w_addr_o  <= '0;
    end else if (!w_req_o || w_ack_i) begin
      if (w_load) begin
        w_req_o   <= 1'b1;
        w_web_o   <= 1'b0;
        w_wid_o   <= r_bank;
        w_addr_o  <= r_base + BANK_DEPTH_LG2'(w_beat_nxt);
        w_wlast_o <= (w_beat_nxt == r_beats - BEAT_W'(1));
      end else begin
        w_req_o   <= 1'b0;
        w_web_o   <= 1'b1;
        w_wlast_o <= 1'b0;
        w_wid_o   <= '0;
        w_addr_o  <= '0;
      end
    end
  end

  assign w_wdata_o = w_req_o ? w_rdata : '0;
endmodule
